// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and default widths for the fetch queue and its neighbours.
//   DATA_WIDTH    : width of instruction, PC, immediate and prediction-PC
//   RAS_PTR_W     : width of the return-address-stack TOS checkpoint
//   fetch_entry_t : one fetched instruction plus its prediction context
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int RAS_PTR_W  = 3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic                  branch_pred;
    logic [DATA_WIDTH-1:0] pc_at_pred;
    logic [RAS_PTR_W-1:0]  ras_tos;
  } fetch_entry_t;

  // Occupancy counter width: one bit wider than the pointers so that a full
  // queue and an empty queue are distinguishable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_param_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_param_if
// Bundles the enqueue (multi-fetch) side, the dequeue (decode) side and the
// status outputs of the fetch queue.
//   fetch_valid_i  : per-lane enqueue valid        (master -> queue)
//   fetch_entry_i  : per-lane enqueue payload      (master -> queue)
//   fetch_ready_o  : all-or-nothing acceptance     (queue  -> master)
//   decode_ready_i : per-lane decode ready         (master -> queue)
//   decode_valid_o : thermometer-coded valid       (queue  -> master)
//   decode_entry_o : head-aligned payload          (queue  -> master)
//   occupancy_o, buffer_empty_o, buffer_full_o, almost_full_o : status
// -----------------------------------------------------------------------------
interface fetch_queue_param_if #(
  parameter int BUFFER_DEPTH = 16,
  parameter int FETCH_WIDTH  = 5,
  parameter int DECODE_WIDTH = 3
);
  import fetch_pkg::*;

  localparam int OCC_W = occ_width(BUFFER_DEPTH);

  logic [FETCH_WIDTH-1:0]                 fetch_valid_i;
  fetch_entry_t [FETCH_WIDTH-1:0]         fetch_entry_i;
  logic                                   fetch_ready_o;
  logic [DECODE_WIDTH-1:0]                decode_ready_i;
  logic [DECODE_WIDTH-1:0]                decode_valid_o;
  fetch_entry_t [DECODE_WIDTH-1:0]        decode_entry_o;
  logic [OCC_W-1:0]                       occupancy_o;
  logic                                   buffer_empty_o;
  logic                                   buffer_full_o;
  logic                                   almost_full_o;

  modport master (
    output fetch_valid_i, fetch_entry_i, decode_ready_i,
    input  fetch_ready_o, decode_valid_o, decode_entry_o,
    input  occupancy_o, buffer_empty_o, buffer_full_o, almost_full_o
  );

  modport slave (
    input  fetch_valid_i, fetch_entry_i, decode_ready_i,
    output fetch_ready_o, decode_valid_o, decode_entry_o,
    output occupancy_o, buffer_empty_o, buffer_full_o, almost_full_o
  );

endinterface

// File: rtl/lead_ones_count.sv
// -----------------------------------------------------------------------------
// lead_ones_count
// Counts the run of consecutive 1s starting at bit 0; everything after the
// first 0 is ignored.
//   i_vec   : input vector, WIDTH bits
//   o_count : length of the leading run of 1s (0..WIDTH)
// -----------------------------------------------------------------------------
module lead_ones_count #(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CNT_W-1:0] o_count
);

  logic w_run;

  // Walk from lane 0 upward; the run ends permanently at the first 0.
  always_comb begin
    o_count = '0;
    w_run   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_run && i_vec[i]) begin
        o_count = o_count + CNT_W'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_queue_param.sv
// -----------------------------------------------------------------------------
// fetch_queue_param
// Circular instruction queue between a multi-lane fetch unit and a multi-lane
// decoder. Up to FETCH_WIDTH entries enter per cycle (all-or-nothing, gated
// on registered free space) and up to DECODE_WIDTH leave per cycle from the
// head, read combinationally with zero latency.
//   clk     : single clock, rising edge
//   reset   : synchronous active-high reset; beats flush and traffic
//   flush_i : discard every entry at the next edge; outputs gated meanwhile
//   bus     : fetch/decode handshake and status (fetch_queue_param_if.slave)
// -----------------------------------------------------------------------------
module fetch_queue_param
  import fetch_pkg::*;
#(
  parameter int BUFFER_DEPTH       = 16,
  parameter int FETCH_WIDTH        = 5,
  parameter int DECODE_WIDTH       = 3,
  parameter int ALMOST_FULL_THRESH = BUFFER_DEPTH - FETCH_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  fetch_queue_param_if.slave   bus
);

  localparam int PTR_W     = $clog2(BUFFER_DEPTH);
  localparam int OCC_W     = occ_width(BUFFER_DEPTH);
  localparam int ENQ_CNT_W = $clog2(FETCH_WIDTH + 1);
  localparam int DEQ_CNT_W = $clog2(DECODE_WIDTH + 1);

  // Highest occupancy that still leaves room for a full fetch group.
  localparam logic [OCC_W-1:0] ENQ_LIMIT = OCC_W'(BUFFER_DEPTH - FETCH_WIDTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUFFER_DEPTH);
  localparam logic [OCC_W-1:0] AF_OCC    = OCC_W'(ALMOST_FULL_THRESH);

  // Payload storage: deliberately never reset or cleared.
  fetch_entry_t           r_ram [BUFFER_DEPTH];

  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [OCC_W-1:0]       r_occ;
  logic                   r_empty;
  logic                   r_full;
  logic                   r_almost_full;
  logic                   r_room;

  logic [ENQ_CNT_W-1:0]   w_fetch_run;
  logic [DEQ_CNT_W-1:0]   w_decode_run;
  logic                   w_fetch_ready;
  logic [ENQ_CNT_W-1:0]   w_enq_cnt;
  logic [OCC_W-1:0]       w_deq_cnt;
  logic [OCC_W-1:0]       w_occ_next;

  lead_ones_count #(
    .WIDTH (FETCH_WIDTH),
    .CNT_W (ENQ_CNT_W)
  ) u_fetch_run (
    .i_vec   (bus.fetch_valid_i),
    .o_count (w_fetch_run)
  );

  lead_ones_count #(
    .WIDTH (DECODE_WIDTH),
    .CNT_W (DEQ_CNT_W)
  ) u_decode_run (
    .i_vec   (bus.decode_ready_i),
    .o_count (w_decode_run)
  );

  // Enqueue/dequeue counts. Acceptance uses only registered free space, so a
  // dequeue in the same cycle never creates room. The decode run is already
  // bounded by DECODE_WIDTH, so only the occupancy bound remains.
  always_comb begin
    w_fetch_ready = 1'b0;
    w_enq_cnt     = '0;
    w_deq_cnt     = '0;
    if (flush_i) begin
      w_fetch_ready = 1'b0;
      w_enq_cnt     = '0;
      w_deq_cnt     = '0;
    end else begin
      w_fetch_ready = r_room;
      if (r_room) begin
        w_enq_cnt = w_fetch_run;
      end else begin
        w_enq_cnt = '0;
      end
      if (OCC_W'(w_decode_run) < r_occ) begin
        w_deq_cnt = OCC_W'(w_decode_run);
      end else begin
        w_deq_cnt = r_occ;
      end
    end
  end

  assign w_occ_next = r_occ + OCC_W'(w_enq_cnt) - w_deq_cnt;

  // Pointer, occupancy and status-flag registers; reset beats flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_occ         <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= (AF_OCC == '0);
      r_room        <= 1'b1;
    end else if (flush_i) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_occ         <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= (AF_OCC == '0);
      r_room        <= 1'b1;
    end else begin
      r_head        <= r_head + PTR_W'(w_deq_cnt);
      r_tail        <= r_tail + PTR_W'(w_enq_cnt);
      r_occ         <= w_occ_next;
      r_empty       <= (w_occ_next == '0);
      r_full        <= (w_occ_next == DEPTH_OCC);
      r_almost_full <= (w_occ_next >= AF_OCC);
      r_room        <= (w_occ_next <= ENQ_LIMIT);
    end
  end

  // Multi-port payload write: lane f lands at tail+f, wrapping naturally.
  always_ff @(posedge clk) begin
    for (int f = 0; f < FETCH_WIDTH; f++) begin
      if (!reset && (ENQ_CNT_W'(f) < w_enq_cnt)) begin
        r_ram[r_tail + PTR_W'(f)] <= bus.fetch_entry_i[f];
      end
    end
  end

  // Head-aligned read: lane d shows head+d; valid is a thermometer of
  // occupancy and is forced low while a flush is pending.
  always_comb begin
    bus.decode_entry_o = '0;
    bus.decode_valid_o = '0;
    for (int d = 0; d < DECODE_WIDTH; d++) begin
      bus.decode_entry_o[d] = r_ram[r_head + PTR_W'(d)];
      bus.decode_valid_o[d] = !flush_i && (r_occ > OCC_W'(d));
    end
  end

  assign bus.fetch_ready_o  = w_fetch_ready;
  assign bus.occupancy_o    = r_occ;
  assign bus.buffer_empty_o = r_empty;
  assign bus.buffer_full_o  = r_full;
  assign bus.almost_full_o  = r_almost_full;

endmodule

// File: doc/fetch_queue_param.md
FETCH_QUEUE_PARAM -- requirements
Module: fetch_queue_param

Interface
REQ-001 DATA_WIDTH, 32, width of instruction, PC, immediate and prediction-PC fields.
REQ-002 BUFFER_DEPTH, 16, number of entries; power of two, at least 2*FETCH_WIDTH.
REQ-003 FETCH_WIDTH, 5, number of enqueue lanes from multi-fetch.
REQ-004 DECODE_WIDTH, 3, number of dequeue lanes to decode.
REQ-005 RAS_PTR_W, 3, width of the RAS TOS checkpoint.
REQ-006 ALMOST_FULL_THRESH, BUFFER_DEPTH-FETCH_WIDTH, occupancy at or above which almost_full_o asserts.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 flush_i  in  1  eager flush; discard all entries.
REQ-010 fetch_valid_i  in  FETCH_WIDTH  per-lane enqueue valid.
REQ-011 fetch_ready_o  out  1  all-or-nothing enqueue acceptance.
REQ-012 fetch_entry_i  in  FETCH_WIDTH x fetch_entry_t  per-lane payload {instruction, pc, imm, branch_pred, pc_at_pred, ras_tos}.
REQ-013 decode_ready_i  in  DECODE_WIDTH  per-lane decode ready.
REQ-014 decode_valid_o  out  DECODE_WIDTH  per-lane output valid, thermometer-coded.
REQ-015 decode_entry_o  out  DECODE_WIDTH x fetch_entry_t  head-aligned payload; lane 0 is the oldest entry.
REQ-016 occupancy_o  out  $clog2(BUFFER_DEPTH)+1  current entry count.
REQ-017 buffer_empty_o, buffer_full_o, almost_full_o  out  1 each  status flags.

Function
REQ-018 Enqueue count SHALL be the number of consecutive 1s in fetch_valid_i starting at lane 0; lanes after the first 0 SHALL be ignored.
REQ-019 fetch_ready_o SHALL be 1 iff (BUFFER_DEPTH - occupancy) >= FETCH_WIDTH, evaluated on registered occupancy only; a same-cycle dequeue gives no credit.
REQ-020 An enqueue SHALL occur only when fetch_ready_o=1 and the enqueue count is greater than 0; accepted entries SHALL be written in lane order at tail, tail+1, and so on, modulo BUFFER_DEPTH.
REQ-021 Bit i of decode_valid_o SHALL equal (occupancy > i); outputs SHALL be driven combinationally from head+i modulo BUFFER_DEPTH, giving zero-cycle read latency.
REQ-022 Dequeue count SHALL equal min(leading-ones count of decode_ready_i, occupancy, DECODE_WIDTH).
REQ-023 Next occupancy SHALL equal occupancy + enq_count - deq_count, and enqueue and dequeue SHALL be legal in the same cycle.
REQ-024 Entries enqueued in cycle N SHALL first appear on decode_valid_o in cycle N+1; there SHALL be no bypass path.
REQ-025 Pointers SHALL be $clog2(BUFFER_DEPTH) bits wide and wrap naturally; occupancy SHALL be one bit wider so that full and empty are distinguishable.
REQ-026 flush_i=1 SHALL set head, tail and occupancy to 0 at the next edge, SHALL take priority over a same-cycle enqueue or dequeue, and SHALL NOT clear the payload RAM.
REQ-027 While flush_i=1, fetch_ready_o SHALL be driven 0 and decode_valid_o SHALL be driven to all 0s.
REQ-028 buffer_empty_o SHALL equal (occupancy==0), buffer_full_o SHALL equal (occupancy==BUFFER_DEPTH), and almost_full_o SHALL equal (occupancy>=ALMOST_FULL_THRESH).
REQ-029 The payload, including ras_tos, SHALL pass through unmodified.

Reset
REQ-030 When reset=1 at a clock edge, head, tail and occupancy SHALL become 0 and reset SHALL take priority over flush_i, enqueue and dequeue.
REQ-031 After reset: decode_valid_o=0, buffer_empty_o=1, buffer_full_o=0, almost_full_o=0, fetch_ready_o=1 and occupancy_o=0; payload RAM SHALL NOT be reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries, and no stale entry SHALL become valid afterwards.

Structure
REQ-033 fetch_entry_t, and the default widths for DATA_WIDTH and RAS_PTR_W, SHALL be defined in the shared package fetch_pkg.
REQ-034 The leading-ones counter SHALL be implemented as one parametrised sub-module, lead_ones_count, instantiated twice: once for fetch_valid_i and once for decode_ready_i.
REQ-035 The payload SHALL be stored as a flat register array, with multi-port writes selected by pointer offset.

Verification
REQ-036 Reset, then enqueue fetch_valid_i=5'b00111 with PCs 0x0, 0x4, 0x8 and decode_ready_i=0 -> next cycle occupancy=3 and decode_valid_o=3'b111 with PCs 0x0, 0x4, 0x8 on lanes 0..2.
REQ-037 With occupancy=11 and fetch_valid_i=5'b11111 -> fetch_ready_o=1 and occupancy becomes 16 with buffer_full_o=1; at occupancy=12, fetch_ready_o=0 and the state is unchanged.
REQ-038 fetch_valid_i=5'b10011 -> exactly 2 entries are enqueued; decode_ready_i=3'b101 with occupancy=5 -> exactly 1 entry is dequeued.
REQ-039 Stream 40 sequential PCs with random decode_ready_i -> PCs emerge strictly in order across the pointer wrap, with no loss or duplication.
REQ-040 With occupancy=9, assert flush_i together with an enqueue of 5 and a dequeue of 3 -> next cycle occupancy=0, buffer_empty_o=1 and decode_valid_o=0.
REQ-041 Assert reset at occupancy=7 while flush_i=0 -> next cycle occupancy=0, fetch_ready_o=1, and a subsequent single enqueue yields exactly one valid entry with the new PC.
